fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Front-end pipeline stage. Holds the PC and reads instructions from a direct-mapped instruction cache.
//  On a miss it refills one line from memory. Each cycle it hands one instruction plus PC+4 to the
//  decode stage, and stalls the pipe while a refill is in progress.
// PARAMETERS
//  ADDR_W    32            virtual address / PC width
//  INST_W    32            instruction width
//  LINES     4             cache lines (power of 2); index = pc[3+log2(LINES):4]
//  LINE_W    128           line width, 4 instructions; word select = pc[3:2]
//  RESET_PC  32'h00001000  boot PC
//  NOP_INST  32'h00000000  encoding injected as a bubble
// PORTS
//  clk                     in   1       clock
//  reset                   in   1       sync, active-high
//  wrt_en                  in   1       pipeline-register enable from hazard logic; 0 = hold
//  branch_taken            in   1       redirect request from ALU stage
//  branch_target           in   ADDR_W  redirect PC; bits [1:0] ignored (treated as 0)
//  mem_req                 out  1       line refill request
//  mem_addr                out  ADDR_W  line-aligned refill address {pc[ADDR_W-1:4],4'b0}
//  mem_ready               in   1       memory returns mem_data this cycle
//  mem_data                in   LINE_W  refill line; word0 in [31:0]
//  PCNEXT_FETCH            out  ADDR_W  registered PC+4 of the issued instruction, to decode
//  instruction             out  INST_W  registered instruction, to decode
//  block_pipe_instr_cache  out  1       combinational; 1 = cache busy, stall pipe
// BEHAVIOUR
//  Reset: pc=RESET_PC; all valid bits=0; state=IDLE; instruction=NOP_INST; PCNEXT_FETCH=0;
//   mem_req=0; mem_addr=0; redirect_pending=0. Reset mid-refill aborts: mem_req drops next cycle.
//  Hit = valid[idx] & tag[idx]==pc[ADDR_W-1:4+log2(LINES)].
//  FSM states: IDLE, MISS, FILL.
//  IDLE:
//   - hit & wrt_en & !branch_taken: instruction<=word, PCNEXT_FETCH<=pc+4, pc<=pc+4.
//     Latency: PC to decode register in 1 cycle; 1 instruction/cycle on hits.
//   - branch_taken (priority over all, needs wrt_en): instruction<=NOP_INST,
//     pc<={branch_target[ADDR_W-1:2],2'b0}; no lookup issued.
//   - miss & !branch_taken: block=1; go MISS; if wrt_en, instruction<=NOP_INST.
//   - wrt_en=0: pc, instruction and PCNEXT_FETCH hold.
//  MISS: mem_req=1, mem_addr held stable until mem_ready=1.
//   - On mem_ready: write line, tag, valid; go FILL.
//   - block=1 throughout; instruction<=NOP_INST when wrt_en.
//  FILL: block=1 for one cycle. Then IDLE with pc<=pending target if redirect_pending, else pc unchanged.
//   The PC then hits.
//  Branch during MISS/FILL: latch target and set redirect_pending (the last request wins).
//   The refill always completes and is never cancelled. redirect_pending clears on entry to IDLE.
//  mem_ready outside MISS is ignored. mem_req is never asserted in IDLE or FILL.
//  PC arithmetic is modulo 2^ADDR_W (0xFFFFFFFC+4 = 0). No line-crossing fetch; one word per cycle.
//  block_pipe_instr_cache = (state!=IDLE) | (state==IDLE & !hit & !branch_taken).
//  Minimum miss penalty = memory latency + 2 cycles.
// TESTING
//  1) Reset, mem_ready one cycle after req, data words = addr -> first mem_addr=0x1000;
//     instructions 0x1000,0x1004,0x1008,0x100C back-to-back after refill; PCNEXT_FETCH=0x1004.. .
//  2) Loop PC 0x1000..0x100C twice -> exactly one mem_req pulse; second pass has no block cycles.
//  3) branch_taken=1, target=0x2003 in IDLE -> instruction=NOP that cycle; next fetch PC=0x2000; miss.
//  4) Branch to 0x3000 during MISS with mem_ready delayed 5 cycles -> line 0x1000 is still filled
//     (valid), then mem_req for 0x3000.
//  5) wrt_en=0 for 3 cycles on a hit -> instruction/PCNEXT_FETCH stable; resumes without skip or duplicate.
//  6) Reset asserted during MISS -> mem_req=0 next cycle; all lines invalid; pc=0x1000;
//     a late mem_ready is ignored.

Source files
------------

// File: rtl/fetch_stage.sv
// Fetch stage: holds the PC, reads a direct-mapped instruction cache and refills one line on a miss.
// Hands one instruction plus PC+4 to decode per cycle and stalls the pipe while a refill is in flight.
module fetch_stage #(
  parameter int                 ADDR_W   = 32,
  parameter int                 INST_W   = 32,
  parameter int                 LINES    = 4,
  parameter int                 LINE_W   = 128,
  parameter logic [ADDR_W-1:0]  RESET_PC = 32'h00001000,
  parameter logic [INST_W-1:0]  NOP_INST = 32'h00000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wrt_en,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_data,
  output logic [ADDR_W-1:0] PCNEXT_FETCH,
  output logic [INST_W-1:0] instruction,
  output logic              block_pipe_instr_cache,
  output logic [1:0]        state_dbg
);

  localparam int WORDS  = LINE_W / INST_W;
  localparam int WORD_W = $clog2(WORDS);
  localparam int OFF_W  = 2 + WORD_W;
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;

  // Handshake: the refill request is held with a stable mem_addr until memory
  // answers with mem_ready=1 in the same cycle; mem_ready at any other time is ignored.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MISS = 2'd1,
    FILL = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              redirect_pending;
  logic [ADDR_W-1:0] redirect_target;

  logic [LINE_W-1:0] line_data [LINES];
  logic [TAG_W-1:0]  line_tag  [LINES];
  logic [LINES-1:0]  line_valid;

  logic [IDX_W-1:0]  pc_idx;
  logic [TAG_W-1:0]  pc_tag;
  logic [WORD_W-1:0] word_sel;
  logic [IDX_W-1:0]  mem_idx;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] target_aligned;
  logic [ADDR_W-1:0] line_addr;
  logic              hit;
  logic [INST_W-1:0] line_words [WORDS];
  logic [INST_W-1:0] fetch_word;
  logic              unused_target_bits;

  assign pc_idx         = pc[OFF_W +: IDX_W];
  assign pc_tag         = pc[ADDR_W-1:OFF_W+IDX_W];
  assign word_sel       = pc[2 +: WORD_W];
  assign mem_idx        = mem_addr[OFF_W +: IDX_W];
  assign pc_plus4       = pc + ADDR_W'(4);
  assign target_aligned = {branch_target[ADDR_W-1:2], 2'b00};
  assign line_addr      = {pc[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign hit            = line_valid[pc_idx] && (line_tag[pc_idx] == pc_tag);
  assign unused_target_bits = ^branch_target[1:0];

  always_comb begin
    for (int w = 0; w < WORDS; w++) begin
      line_words[w] = line_data[pc_idx][w*INST_W +: INST_W];
    end
  end

  assign fetch_word = line_words[word_sel];

  // A taken branch in IDLE suppresses the miss stall: no lookup is issued for the old PC.
  assign block_pipe_instr_cache = (state != IDLE) || (!hit && !branch_taken);
  assign state_dbg = state;

  // Line storage needs no reset; the valid bits alone decide whether it is used.
  always_ff @(posedge clk) begin
    if (state == MISS && mem_ready) begin
      line_data[mem_idx] <= mem_data;
      line_tag[mem_idx]  <= mem_addr[ADDR_W-1:OFF_W+IDX_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      pc               <= RESET_PC;
      line_valid       <= '0;
      instruction      <= NOP_INST;
      PCNEXT_FETCH     <= '0;
      mem_req          <= 1'b0;
      mem_addr         <= '0;
      redirect_pending <= 1'b0;
      redirect_target  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (branch_taken) begin
            if (wrt_en) begin
              instruction <= NOP_INST;
              pc          <= target_aligned;
            end
          end else if (hit) begin
            if (wrt_en) begin
              instruction  <= fetch_word;
              PCNEXT_FETCH <= pc_plus4;
              pc           <= pc_plus4;
            end
          end else begin
            state    <= MISS;
            mem_req  <= 1'b1;
            mem_addr <= line_addr;
            if (wrt_en) instruction <= NOP_INST;
          end
        end
        MISS: begin
          // The refill always completes; a branch here is only remembered.
          if (branch_taken) begin
            redirect_pending <= 1'b1;
            redirect_target  <= target_aligned;
          end
          if (wrt_en) instruction <= NOP_INST;
          if (mem_ready) begin
            line_valid[mem_idx] <= 1'b1;
            mem_req             <= 1'b0;
            state               <= FILL;
          end
        end
        FILL: begin
          state            <= IDLE;
          redirect_pending <= 1'b0;
          if (wrt_en) instruction <= NOP_INST;
          // A branch arriving in this last busy cycle is the newest request and wins.
          if (branch_taken)          pc <= target_aligned;
          else if (redirect_pending) pc <= redirect_target;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic against a behavioural
// model of the PC, the cache contents and the refill/redirect rules.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         wrt_en = 1'b0;
  logic         branch_taken = 1'b0;
  logic [31:0]  branch_target = '0;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ready = 1'b0;
  logic [127:0] mem_data;
  logic [31:0]  PCNEXT_FETCH;
  logic [31:0]  instruction;
  logic         block_pipe_instr_cache;
  logic [1:0]   state_dbg;

  int errors = 0;
  int checks = 0;

  fetch_stage dut (
    .clk                    (clk),
    .reset                  (reset),
    .wrt_en                 (wrt_en),
    .branch_taken           (branch_taken),
    .branch_target          (branch_target),
    .mem_req                (mem_req),
    .mem_addr               (mem_addr),
    .mem_ready              (mem_ready),
    .mem_data               (mem_data),
    .PCNEXT_FETCH           (PCNEXT_FETCH),
    .instruction            (instruction),
    .block_pipe_instr_cache (block_pipe_instr_cache),
    .state_dbg              (state_dbg)
  );

  // ---------------- clock / memory ----------------
  always #5 clk = ~clk;

  // Memory image: every word holds its own address.
  function automatic logic [127:0] line_of(input logic [31:0] a);
    line_of = {a[31:4], 4'hC, a[31:4], 4'h8, a[31:4], 4'h4, a[31:4], 4'h0};
  endfunction

  assign mem_data = line_of(mem_addr);

  int lat = 1;
  int wait_cnt = 0;
  bit force_rdy = 1'b0;

  // ---------------- reference model ----------------
  logic [31:0] m_pc, m_inst, m_pcn, m_req_addr, m_redir_pc;
  bit          m_wait, m_fill, m_redir;
  logic [27:0] m_line [4];
  bit          m_valid [4];

  function automatic bit m_hit();
    m_hit = m_valid[m_pc[5:4]] && (m_line[m_pc[5:4]] == m_pc[31:4]);
  endfunction

  task automatic model_step(input bit rst, input bit we, input bit bt,
                            input logic [31:0] tgt, input bit rdy);
    logic [31:0] t;
    t = {tgt[31:2], 2'b00};
    if (rst) begin
      m_pc = 32'h1000; m_inst = NOP; m_pcn = 0; m_req_addr = 0;
      m_wait = 0; m_fill = 0; m_redir = 0; m_redir_pc = 0;
      for (int i = 0; i < 4; i++) m_valid[i] = 0;
    end else if (m_wait) begin
      if (bt) begin m_redir = 1; m_redir_pc = t; end
      if (we) m_inst = NOP;
      if (rdy) begin
        m_valid[m_req_addr[5:4]] = 1;
        m_line[m_req_addr[5:4]]  = m_req_addr[31:4];
        m_wait = 0;
        m_fill = 1;
      end
    end else if (m_fill) begin
      if (we) m_inst = NOP;
      if (bt) m_pc = t;
      else if (m_redir) m_pc = m_redir_pc;
      m_redir = 0;
      m_fill = 0;
    end else if (bt) begin
      if (we) begin m_inst = NOP; m_pc = t; end
    end else if (m_hit()) begin
      if (we) begin m_inst = m_pc; m_pcn = m_pc + 4; m_pc = m_pc + 4; end
    end else begin
      m_wait = 1;
      m_req_addr = {m_pc[31:4], 4'h0};
      if (we) m_inst = NOP;
    end
  endtask

  // ---------------- driver ----------------
  bit          obs_block, exp_block, prev_req;
  int          req_pulses = 0;
  int          block_cycles = 0;
  logic [31:0] req_addr_q[$];

  task automatic cycle(input bit we, input bit bt, input logic [31:0] tgt);
    wrt_en = we;
    branch_taken = bt;
    branch_target = tgt;
    mem_ready = force_rdy || (mem_req === 1'b1 && wait_cnt >= lat);
    if (mem_req === 1'b1) wait_cnt++;
    else wait_cnt = 0;
    #1;
    obs_block = block_pipe_instr_cache;
    exp_block = m_wait || m_fill || (!m_hit() && !bt);
    if (obs_block) block_cycles++;
    prev_req = (mem_req === 1'b1);
    model_step(reset, we, bt, tgt, mem_ready);
    @(posedge clk);
    #1;
    if (mem_req === 1'b1 && !prev_req) begin
      req_pulses++;
      req_addr_q.push_back(mem_addr);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    reset = 1'b0;
    checks++; if (instruction !== NOP) begin errors++; $display("FAIL reset_instruction got=%h want=%h", instruction, NOP); end
    checks++; if (PCNEXT_FETCH !== 32'h0) begin errors++; $display("FAIL reset_pcnext got=%h want=0", PCNEXT_FETCH); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got=%b want=0", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr); end
    checks++; if (block_pipe_instr_cache !== 1'b1) begin errors++; $display("FAIL reset_block got=%b want=1", block_pipe_instr_cache); end
  endtask

  task automatic test_cold_fetch();
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int n;
    lat = 1; req_pulses = 0; req_addr_q.delete();
    exp_q = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
    n = 0;
    while (got_q.size() < 4 && n < 30) begin
      cycle(1, 0, 0);
      n++;
      checks++; if (obs_block !== exp_block) begin errors++; $display("FAIL cold_block got=%b want=%b", obs_block, exp_block); end
      checks++; if (instruction !== m_inst) begin errors++; $display("FAIL cold_instruction got=%h want=%h", instruction, m_inst); end
      checks++; if (mem_req !== m_wait) begin errors++; $display("FAIL cold_mem_req got=%b want=%b", mem_req, m_wait); end
      if (instruction !== NOP) got_q.push_back(instruction);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL cold_sequence[%0d] got=%h want=%h", i, (i < got_q.size()) ? got_q[i] : 32'hx, exp_q[i]);
      end
    end
    checks++; if (PCNEXT_FETCH !== 32'h1010) begin errors++; $display("FAIL cold_pcnext got=%h want=00001010", PCNEXT_FETCH); end
    checks++; if (req_pulses != 1) begin errors++; $display("FAIL cold_req_pulses got=%0d want=1", req_pulses); end
    checks++;
    if (req_addr_q.size() != 1 || req_addr_q[0] !== 32'h1000) begin
      errors++;
      $display("FAIL cold_mem_addr got=%h want=00001000", (req_addr_q.size() > 0) ? req_addr_q[0] : 32'hx);
    end
  endtask

  task automatic test_loop_hit();
    logic [31:0] want;
    req_pulses = 0; block_cycles = 0;
    cycle(1, 1, 32'h1000);
    checks++; if (instruction !== NOP) begin errors++; $display("FAIL loop_branch_nop got=%h want=%h", instruction, NOP); end
    for (int i = 0; i < 4; i++) begin
      want = 32'h1000 + 32'(i * 4);
      cycle(1, 0, 0);
      checks++; if (instruction !== want) begin errors++; $display("FAIL loop_instruction got=%h want=%h", instruction, want); end
      checks++; if (PCNEXT_FETCH !== want + 4) begin errors++; $display("FAIL loop_pcnext got=%h want=%h", PCNEXT_FETCH, want + 4); end
    end
    checks++; if (req_pulses != 0) begin errors++; $display("FAIL loop_req_pulses got=%0d want=0", req_pulses); end
    checks++; if (block_cycles != 0) begin errors++; $display("FAIL loop_block_cycles got=%0d want=0", block_cycles); end
  endtask

  task automatic test_branch_idle();
    int n;
    cycle(1, 1, 32'h2003);
    checks++; if (instruction !== NOP) begin errors++; $display("FAIL br_idle_nop got=%h want=%h", instruction, NOP); end
    checks++; if (obs_block !== 1'b0) begin errors++; $display("FAIL br_idle_block got=%b want=0", obs_block); end
    cycle(1, 0, 0);
    checks++; if (obs_block !== 1'b1) begin errors++; $display("FAIL br_idle_miss_block got=%b want=1", obs_block); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h2000) begin errors++; $display("FAIL br_idle_req got=%b/%h want=1/00002000", mem_req, mem_addr); end
    n = 0;
    while (instruction === NOP && n < 20) begin
      cycle(1, 0, 0);
      n++;
      checks++; if (obs_block !== exp_block) begin errors++; $display("FAIL br_idle_fill_block got=%b want=%b", obs_block, exp_block); end
    end
    checks++; if (instruction !== 32'h2000 || PCNEXT_FETCH !== 32'h2004) begin errors++; $display("FAIL br_idle_fetch got=%h/%h want=00002000/00002004", instruction, PCNEXT_FETCH); end
  endtask

  task automatic test_branch_during_miss();
    logic [31:0] exp_q[$];
    int n;
    lat = 5; req_addr_q.delete();
    exp_q = '{32'h1000, 32'h3000};
    cycle(1, 1, 32'h1000);
    cycle(1, 0, 0);
    cycle(1, 1, 32'h3000);
    n = 0;
    while (instruction === NOP && n < 40) begin
      cycle(1, 0, 0);
      n++;
      checks++; if (obs_block !== exp_block) begin errors++; $display("FAIL brmiss_block got=%b want=%b", obs_block, exp_block); end
      checks++; if (mem_req !== m_wait) begin errors++; $display("FAIL brmiss_mem_req got=%b want=%b", mem_req, m_wait); end
      if (m_wait) begin
        checks++; if (mem_addr !== m_req_addr) begin errors++; $display("FAIL brmiss_mem_addr got=%h want=%h", mem_addr, m_req_addr); end
      end
    end
    checks++; if (instruction !== 32'h3000) begin errors++; $display("FAIL brmiss_fetch got=%h want=00003000", instruction); end
    checks++; if (req_addr_q.size() != 2) begin errors++; $display("FAIL brmiss_req_count got=%0d want=2", req_addr_q.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= req_addr_q.size() || req_addr_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL brmiss_req_addr[%0d] got=%h want=%h", i, (i < req_addr_q.size()) ? req_addr_q[i] : 32'hx, exp_q[i]);
      end
    end
  endtask

  task automatic test_stall();
    int n;
    lat = 1;
    cycle(1, 0, 0);
    checks++; if (instruction !== 32'h3004 || PCNEXT_FETCH !== 32'h3008) begin errors++; $display("FAIL stall_pre got=%h/%h want=00003004/00003008", instruction, PCNEXT_FETCH); end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0);
      checks++; if (instruction !== 32'h3004 || PCNEXT_FETCH !== 32'h3008) begin errors++; $display("FAIL stall_hold got=%h/%h want=00003004/00003008", instruction, PCNEXT_FETCH); end
      checks++; if (obs_block !== 1'b0) begin errors++; $display("FAIL stall_block got=%b want=0", obs_block); end
    end
    cycle(1, 0, 0);
    checks++; if (instruction !== 32'h3008 || PCNEXT_FETCH !== 32'h300C) begin errors++; $display("FAIL stall_resume got=%h/%h want=00003008/0000300c", instruction, PCNEXT_FETCH); end
    cycle(1, 0, 0);
    checks++; if (instruction !== 32'h300C || PCNEXT_FETCH !== 32'h3010) begin errors++; $display("FAIL stall_next got=%h/%h want=0000300c/00003010", instruction, PCNEXT_FETCH); end
    n = 0;
    while (m_inst !== 32'h3010 && n < 20) begin
      cycle(1, 0, 0);
      n++;
      checks++; if (instruction !== m_inst) begin errors++; $display("FAIL stall_cross got=%h want=%h", instruction, m_inst); end
    end
  endtask

  task automatic test_reset_mid_miss();
    int n;
    lat = 50;
    cycle(1, 1, 32'h4000);
    cycle(1, 0, 0);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h4000) begin errors++; $display("FAIL rstmiss_req got=%b/%h want=1/00004000", mem_req, mem_addr); end
    cycle(1, 0, 0);
    reset = 1'b1;
    cycle(1, 0, 0);
    reset = 1'b0;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rstmiss_req_drop got=%b want=0", mem_req); end
    checks++; if (instruction !== NOP || PCNEXT_FETCH !== 32'h0) begin errors++; $display("FAIL rstmiss_outputs got=%h/%h want=%h/0", instruction, PCNEXT_FETCH, NOP); end
    force_rdy = 1'b1;
    cycle(1, 0, 0);
    force_rdy = 1'b0;
    checks++; if (obs_block !== 1'b1) begin errors++; $display("FAIL rstmiss_block got=%b want=1", obs_block); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h1000) begin errors++; $display("FAIL rstmiss_late_ready got=%b/%h want=1/00001000", mem_req, mem_addr); end
    lat = 2;
    n = 0;
    while (instruction === NOP && n < 30) begin
      cycle(1, 0, 0);
      n++;
      checks++; if (mem_req !== m_wait) begin errors++; $display("FAIL rstmiss_refill_req got=%b want=%b", mem_req, m_wait); end
    end
    checks++; if (instruction !== 32'h1000) begin errors++; $display("FAIL rstmiss_fetch got=%h want=00001000", instruction); end
    cycle(1, 1, 32'h3010);
    cycle(1, 0, 0);
    checks++; if (obs_block !== 1'b1) begin errors++; $display("FAIL rstmiss_invalidated got=%b want=1", obs_block); end
  endtask

  task automatic test_wrap();
    int n;
    lat = 1;
    cycle(1, 1, 32'hFFFF_FFF8);
    n = 0;
    while (m_pcn !== 32'h4 && n < 40) begin
      cycle(1, 0, 0);
      n++;
      checks++; if (PCNEXT_FETCH !== m_pcn) begin errors++; $display("FAIL wrap_pcnext got=%h want=%h", PCNEXT_FETCH, m_pcn); end
    end
    checks++; if (PCNEXT_FETCH !== 32'h4 || instruction !== 32'h0) begin errors++; $display("FAIL wrap_end got=%h/%h want=00000004/00000000", PCNEXT_FETCH, instruction); end
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    bit we, bt;
    for (int c = 0; c < 600; c++) begin
      lat = $urandom_range(0, 3);
      force_rdy = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 199) == 0);
      we = ($urandom_range(0, 3) != 0);
      bt = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0: tgt = 32'h1000 + ($urandom_range(0, 127) << 2) + $urandom_range(0, 3);
        1: tgt = 32'hFFFF_FFE0 + ($urandom_range(0, 7) << 2);
        2: tgt = $urandom_range(0, 63) << 2;
        default: tgt = $urandom;
      endcase
      cycle(we, bt, tgt);
      checks++; if (obs_block !== exp_block) begin errors++; $display("FAIL rand_block cyc=%0d got=%b want=%b", c, obs_block, exp_block); end
      checks++; if (instruction !== m_inst) begin errors++; $display("FAIL rand_instruction cyc=%0d got=%h want=%h", c, instruction, m_inst); end
      checks++; if (PCNEXT_FETCH !== m_pcn) begin errors++; $display("FAIL rand_pcnext cyc=%0d got=%h want=%h", c, PCNEXT_FETCH, m_pcn); end
      checks++; if (mem_req !== m_wait) begin errors++; $display("FAIL rand_mem_req cyc=%0d got=%b want=%b", c, mem_req, m_wait); end
      if (m_wait) begin
        checks++; if (mem_addr !== m_req_addr) begin errors++; $display("FAIL rand_mem_addr cyc=%0d got=%h want=%h", c, mem_addr, m_req_addr); end
      end
    end
    reset = 1'b0;
    force_rdy = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_step(1, 0, 0, 0, 0);
    test_reset();
    test_cold_fetch();
    test_loop_hit();
    test_branch_idle();
    test_branch_during_miss();
    test_stall();
    test_reset_mid_miss();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog timeout");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
